// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment definitions (glyph table, nibble and FSM types).
// Rev 1.0
`default_nettype none

package seg_pkg;

  localparam int SEG_W = 8;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Active-low gfedcba patterns, index = hex value; the encoder uses this same table.
  localparam logic [15:0][6:0] C_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/seg_patron_a_hex.sv
// seg_patron_a_hex: combinational 7-bit segment pattern to {match, nibble} lookup.
// Rev 1.0
`default_nettype none

module seg_patron_a_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_match,
  output nibble_t    o_nibble
);

  always_comb begin
    o_match  = 1'b0;
    o_nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == C_GLYPH[i]) begin
        o_match  = 1'b1;
        o_nibble = nibble_t'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/decodificador_segmentos.sv
// decodificador_segmentos: sniffs a multiplexed active-low 7-seg bus and recovers digits.
// Rev 1.0
`default_nettype none

module decodificador_segmentos
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     valid_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]    r_seg_m, r_seg_s, r_seg_p;
  logic [DIGITS-1:0]   r_an_m, r_an_s, r_an_p;
  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_commit;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_dp, r_valid, r_err, r_seen;
  logic                r_frame;

  logic [IDX_W:0]      w_zeros;
  logic [IDX_W-1:0]    w_idx;
  logic                w_an_legal;
  logic                w_change;
  logic                w_match;
  nibble_t             w_nibble;
  logic [DIGITS-1:0]   w_commit_mask;

  seg_patron_a_hex u_lookup (
    .i_pattern (r_seg_s[6:0]),
    .o_match   (w_match),
    .o_nibble  (w_nibble)
  );

  always_comb begin
    w_zeros = '0;
    w_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_an_s[i]) begin
        w_zeros = w_zeros + 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign w_an_legal    = (w_zeros == (IDX_W+1)'(1));
  assign w_change      = (r_seg_s != r_seg_p) || (r_an_s != r_an_p);
  assign w_commit_mask = w_commit ? (DIGITS'(1) << w_idx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_an_legal) w_state_nxt = ST_SETTLING;
      end
      ST_SETTLING: begin
        if (!w_an_legal) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_change) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        w_cnt_nxt = '0;
        if (!w_an_legal)   w_state_nxt = ST_IDLE;
        else if (w_change) w_state_nxt = ST_SETTLING;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_m  <= '1;
      r_seg_s  <= '1;
      r_seg_p  <= '1;
      r_an_m   <= '1;
      r_an_s   <= '1;
      r_an_p   <= '1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_digits <= '0;
      r_dp     <= '0;
      r_valid  <= '0;
      r_err    <= '0;
      r_seen   <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_seg_m <= seg_in;
      r_seg_s <= r_seg_m;
      r_seg_p <= r_seg_s;
      r_an_m  <= an_in;
      r_an_s  <= r_an_m;
      r_an_p  <= r_an_s;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        // An unrecognised pattern keeps the last good nibble and only flags the error.
        if (w_match) r_digits[4*w_idx +: 4] <= w_nibble;
        r_valid[w_idx] <= w_match;
        r_err[w_idx]   <= ~w_match;
        r_dp[w_idx]    <= ~r_seg_s[7];
      end
      if (r_seen == '1) begin
        r_frame <= 1'b1;
        r_seen  <= w_commit_mask;
      end else begin
        r_frame <= 1'b0;
        r_seen  <= r_seen | w_commit_mask;
      end
    end
  end

  assign digits_out = r_digits;
  assign dp_out     = r_dp;
  assign valid_out  = r_valid;
  assign err_out    = r_err;
  assign frame_done = r_frame;

endmodule

`default_nettype wire
